fetch_queue_arm: RTL and testbench



---
 rtl/arm_fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_queue_arm.sv | 76 +++++++
 tb/tb_fetch_queue_arm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared constants for the ARM fetch front end
package arm_fetch_pkg;

  // Instruction word width; every queue entry is {pc, instr} packed as N + INSTR_W bits
  localparam int INSTR_W = 32;

  // Byte distance between sequential fetches
  localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic synchronous FIFO with single-cycle flush
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: flush clears occupancy and pointers; otherwise push/pop update independently
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset dominates flush, push and pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents after reset are don't-care so it carries no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Status and head-of-queue view, all from registered state
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/fetch_queue_arm.sv
// rtl/fetch_queue_arm.sv - fetch stage: PC register, instruction memory drive and decode queue
module fetch_queue_arm
  import arm_fetch_pkg::*;
#(
  parameter int           N        = 64,
  parameter int           DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [N-1:0]               IM_addr,
  input  logic [INSTR_W-1:0]         IM_readData,
  input  logic                       redirect,
  input  logic [N-1:0]               redirect_target,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [INSTR_W-1:0]         id_instr,
  output logic [N-1:0]               id_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int           ENTRY_W    = N + INSTR_W;
  localparam logic [N-1:0] ALIGN_MASK = ~N'(3);

  logic [N-1:0]       pc_q, pc_d;
  logic               push, pop;
  logic               full, empty;
  logic [ENTRY_W-1:0] head;

  // Handshake gating and next PC; redirect wins and suppresses both push and pop
  always_comb begin
    push = fetch_en && !full && !redirect;
    pop  = !empty && id_ready && !redirect;
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_target & ALIGN_MASK;
    end else if (push) begin
      pc_d = pc_q + N'(PC_INCR);
    end
  end

  // PC register; the fetch address is this flop directly, so id_ready never reaches IM_addr
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wr_data ({pc_q, IM_readData}),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .head    (head)
  );

  // Decode-side outputs; head fields are forced to zero while the queue is empty
  always_comb begin
    IM_addr  = pc_q;
    id_valid = !empty;
    id_pc    = empty ? '0 : head[ENTRY_W-1:INSTR_W];
    id_instr = empty ? '0 : head[INSTR_W-1:0];
  end

endmodule

// File: tb/tb_fetch_queue_arm.sv
// tb/tb_fetch_queue_arm.sv - self-checking bench for fetch_queue_arm
module tb_fetch_queue_arm;

  localparam int           N        = 64;
  localparam int           DEPTH    = 4;
  localparam logic [N-1:0] RESET_PC = '0;
  localparam int           CNT_W    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_en;
  logic [N-1:0]     IM_addr;
  logic [31:0]      IM_readData;
  logic             redirect;
  logic [N-1:0]     redirect_target;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_instr;
  logic [N-1:0]     id_pc;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  // Instruction memory: word = byte address / 4
  assign IM_readData = 32'(IM_addr >> 2);

  fetch_queue_arm #(
    .N        (N),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_en        (fetch_en),
    .IM_addr         (IM_addr),
    .IM_readData     (IM_readData),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .count           (count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: next fetch address plus an ordered list of queued PCs
  logic [N-1:0] m_pc;
  logic [N-1:0] m_q[$];
  logic [N-1:0] saved_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic fe, input logic rd,
                              input logic [N-1:0] tgt, input logic rdy);
    bit do_push;
    bit do_pop;
    if (r) begin
      m_pc = RESET_PC;
      m_q.delete();
    end else if (rd) begin
      m_pc = {tgt[N-1:2], 2'b00};
      m_q.delete();
    end else begin
      do_push = fe && (m_q.size() < DEPTH);
      do_pop  = (m_q.size() > 0) && rdy;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_pc;
    logic [31:0]  exp_instr;
    exp_pc    = (m_q.size() != 0) ? m_q[0] : '0;
    exp_instr = (m_q.size() != 0) ? 32'(m_q[0] >> 2) : 32'h0;
    chk("IM_addr",  64'(IM_addr),  64'(m_pc));
    chk("count",    64'(count),    64'(m_q.size()));
    chk("id_valid", 64'(id_valid), 64'(m_q.size() != 0));
    chk("id_pc",    64'(id_pc),    64'(exp_pc));
    chk("id_instr", 64'(id_instr), 64'(exp_instr));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare 1 ns later
  task automatic step(input logic r, input logic fe, input logic rd,
                      input logic [N-1:0] tgt, input logic rdy);
    reset           = r;
    fetch_en        = fe;
    redirect        = rd;
    redirect_target = tgt;
    id_ready        = rdy;
    @(posedge clk);
    model_update(r, fe, rd, tgt, rdy);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0;
    redirect_target = '0; id_ready = 1'b0;
    m_pc = RESET_PC;

    // Reset state
    repeat (2) step(1, 0, 0, '0, 0);
    chk("rst_addr",   64'(IM_addr),  64'h0);
    chk("rst_count",  64'(count),    64'h0);
    chk("rst_valid",  64'(id_valid), 64'h0);
    chk("rst_instr",  64'(id_instr), 64'h0);
    chk("rst_pc",     64'(id_pc),    64'h0);

    // Streaming at one instruction per cycle
    step(0, 1, 0, '0, 1);
    chk("stream0_pc",    64'(id_pc),    64'h0);
    chk("stream0_valid", 64'(id_valid), 64'h1);
    chk("stream0_addr",  64'(IM_addr),  64'h4);
    step(0, 1, 0, '0, 1);
    chk("stream1_pc",    64'(id_pc),    64'h4);
    chk("stream1_instr", 64'(id_instr), 64'h1);
    repeat (4) step(0, 1, 0, '0, 1);

    // Back-pressure from reset: fill to DEPTH, then drain
    step(1, 0, 0, '0, 0);
    repeat (6) step(0, 1, 0, '0, 0);
    chk("full_count", 64'(count),   64'd4);
    chk("full_addr",  64'(IM_addr), 64'd16);
    chk("full_pc",    64'(id_pc),   64'h0);
    repeat (8) step(0, 1, 0, '0, 1);

    // Redirect with three entries queued
    step(1, 0, 0, '0, 0);
    repeat (3) step(0, 1, 0, '0, 0);
    chk("pre_redir_count", 64'(count), 64'd3);
    step(0, 1, 1, 64'h1003, 1);
    chk("redir_count", 64'(count),    64'h0);
    chk("redir_valid", 64'(id_valid), 64'h0);
    chk("redir_addr",  64'(IM_addr),  64'h1000);
    step(0, 1, 0, '0, 1);
    chk("redir_pc",    64'(id_pc),    64'h1000);
    chk("redir_instr", 64'(id_instr), 64'h400);

    // PC wrap at 2^N, then pointer wrap with mixed back-pressure
    step(0, 1, 1, '1, 1);
    chk("wrap_pre_addr", 64'(IM_addr), 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 1, 0, '0, 1);
    chk("wrap_addr", 64'(IM_addr), 64'h0);
    chk("wrap_pc",   64'(id_pc),   64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 3 * (2 * DEPTH + 1); i++) begin
      step(0, 1, 0, '0, (i % 3) != 0);
    end

    // Reset overrides redirect while full
    repeat (6) step(0, 1, 0, '0, 0);
    chk("pre_rst_count", 64'(count), 64'd4);
    step(1, 1, 1, 64'h2000, 1);
    chk("midrst_addr",  64'(IM_addr),  64'(RESET_PC));
    chk("midrst_count", 64'(count),    64'h0);
    chk("midrst_instr", 64'(id_instr), 64'h0);

    // fetch_en low mid-stream: PC frozen, queue drains
    repeat (3) step(0, 1, 0, '0, 1);
    repeat (2) step(0, 1, 0, '0, 0);
    saved_addr = IM_addr;
    repeat (4) step(0, 0, 0, '0, 1);
    chk("freeze_addr",  64'(IM_addr),  64'(saved_addr));
    chk("freeze_count", 64'(count),    64'h0);
    chk("freeze_valid", 64'(id_valid), 64'h0);

    // Redirect wins even with fetch_en low
    step(0, 0, 1, 64'h3002, 1);
    chk("redir_fe0_addr", 64'(IM_addr), 64'h3000);
    repeat (3) step(0, 1, 0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
